// File: rtl/wb_sequencer_if.sv
// Handshake bundle between main control and the write-back sequencer.
// The master side issues requests; the slave side drives the mux selects.
interface wb_sequencer_if;
   logic       start;
   logic [2:0] wb_kind;
   logic       mem_ready;
   logic       flush;
   logic [1:0] wreg_sel;
   logic [1:0] wdata_sel;
   logic       reg_wr;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output start, wb_kind, mem_ready, flush,
      input  wreg_sel, wdata_sel, reg_wr,
      input  busy, done, err
   );

   modport slave (
      input  start, wb_kind, mem_ready, flush,
      output wreg_sel, wdata_sel, reg_wr,
      output busy, done, err
   );
endinterface

// File: rtl/wb_sequencer.sv
// Register-file write-back sequencer for the multicycle MIPS datapath.
// Moore FSM; every output is registered alongside the next state.
module wb_sequencer #(
   parameter int MEM_TIMEOUT = 16
) (
   input logic            clk,
   input logic            reset,
   wb_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, WAIT_MEM, WRITE1, WRITE2, FIN
   } state_t;

   typedef enum logic [2:0] {
      K_NONE   = 3'd0,
      K_LOAD   = 3'd1,
      K_ALU_RD = 3'd2,
      K_LINK   = 3'd3,
      K_PUSH   = 3'd4,
      K_POP    = 3'd5,
      K_ALU_RT = 3'd6,
      K_BAD    = 3'd7
   } kind_t;

   typedef struct packed {
      logic [1:0] wreg_sel;
      logic [1:0] wdata_sel;
      logic       reg_wr;
      logic       busy;
      logic       done;
      logic       err;
   } out_t;

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   kind_t      kind;
   logic [7:0] cnt;
   out_t       o;

   // Output image of a state, evaluated for the state being entered
   function automatic out_t dec(state_t s, kind_t k, logic e);
      out_t r;
      r      = '0;
      r.busy = (s != IDLE);
      case (s)
         WRITE1: begin
            r.reg_wr = 1'b1;
            r.done   = (k != K_POP);
            case (k)
               K_ALU_RD: r.wreg_sel = 2'b11;
               K_LINK: begin
                  r.wreg_sel  = 2'b10;
                  r.wdata_sel = 2'b10;
               end
               K_PUSH:        r.wreg_sel  = 2'b01;
               K_LOAD, K_POP: r.wdata_sel = 2'b01;
               default: ;
            endcase
         end
         WRITE2: begin
            r.reg_wr   = 1'b1;
            r.wreg_sel = 2'b01;
            r.done     = 1'b1;
         end
         FIN: begin
            r.done = 1'b1;
            r.err  = e;
         end
         default: ;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         kind  <= K_NONE;
         cnt   <= '0;
         o     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  kind <= kind_t'(bus.wb_kind);
                  cnt  <= '0;
                  case (kind_t'(bus.wb_kind))
                     K_NONE, K_BAD: begin
                        state <= FIN;
                        o <= dec(FIN, kind_t'(bus.wb_kind),
                                 bus.wb_kind == K_BAD);
                     end
                     K_LOAD, K_POP: begin
                        state <= WAIT_MEM;
                        o <= dec(WAIT_MEM, kind_t'(bus.wb_kind), 1'b0);
                     end
                     default: begin
                        state <= WRITE1;
                        o <= dec(WRITE1, kind_t'(bus.wb_kind), 1'b0);
                     end
                  endcase
               end
            end
            WAIT_MEM: begin
               // flush wins, then mem_ready, then the timeout
               if (bus.flush) begin
                  state <= IDLE;
                  o     <= '0;
               end else if (bus.mem_ready) begin
                  state <= WRITE1;
                  o     <= dec(WRITE1, kind, 1'b0);
               end else if (cnt == TO_LAST) begin
                  state <= FIN;
                  o     <= dec(FIN, kind, 1'b1);
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            WRITE1: begin
               if (!bus.flush && kind == K_POP) begin
                  state <= WRITE2;
                  o     <= dec(WRITE2, kind, 1'b0);
               end else begin
                  state <= IDLE;
                  o     <= '0;
               end
            end
            default: begin
               state <= IDLE;
               o     <= '0;
            end
         endcase
      end
   end

   assign bus.wreg_sel  = o.wreg_sel;
   assign bus.wdata_sel = o.wdata_sel;
   assign bus.reg_wr    = o.reg_wr;
   assign bus.busy      = o.busy;
   assign bus.done      = o.done;
   assign bus.err       = o.err;

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer with MEM_TIMEOUT=4.
// Each driven cycle queues the outputs expected after the next edge.
module tb_wb_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   string      tag_q[$];
   logic [7:0] exp_q[$];

   wb_sequencer_if bus();

   wb_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {wreg_sel, wdata_sel, reg_wr, busy, done, err}
   function automatic logic [7:0] ev(
      logic [1:0] ws, logic [1:0] wd,
      logic wr, logic bz, logic dn, logic er
   );
      return {ws, wd, wr, bz, dn, er};
   endfunction

   function automatic logic [7:0] obs();
      return {bus.wreg_sel, bus.wdata_sel, bus.reg_wr,
              bus.busy, bus.done, bus.err};
   endfunction

   task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, got, exp);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0)
         check(tag_q.pop_front(), obs(), exp_q.pop_front());
   end

   // Called at a negedge: drive inputs for the coming edge and
   // queue the outputs expected in the cycle after it.
   task automatic cyc(
      logic st, logic [2:0] k, logic mr, logic fl,
      logic [7:0] e, string tag
   );
      bus.start     = st;
      bus.wb_kind   = k;
      bus.mem_ready = mr;
      bus.flush     = fl;
      tag_q.push_back(tag);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   logic [7:0] IDL, WM, LD1, W2;

   initial begin
      IDL = ev(2'b00, 2'b00, 0, 0, 0, 0);
      WM  = ev(2'b00, 2'b00, 0, 1, 0, 0);
      LD1 = ev(2'b00, 2'b01, 1, 1, 1, 0);
      W2  = ev(2'b01, 2'b00, 1, 1, 1, 0);

      bus.start     = 1'b0;
      bus.wb_kind   = 3'd0;
      bus.mem_ready = 1'b0;
      bus.flush     = 1'b0;
      #1 check("reset_state", obs(), IDL);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc(0, 3'd0, 0, 0, IDL, "idle_after_reset");

      // POP interrupted by reset in WRITE1
      cyc(1, 3'd5, 1, 0, WM, "pop_rst_wm");
      cyc(0, 3'd0, 1, 0, ev(2'b00, 2'b01, 1, 1, 0, 0), "pop_rst_w1");
      reset = 1'b1;
      #1 check("reset_mid_pop", obs(), IDL);
      @(negedge clk);
      reset = 1'b0;
      cyc(0, 3'd0, 0, 0, IDL, "no_write2");
      cyc(1, 3'd2, 0, 0, ev(2'b11, 2'b00, 1, 1, 1, 0), "alu_rd");
      cyc(0, 3'd0, 0, 0, IDL, "alu_rd_idle");

      // POP with mem_ready rising in cycle 3
      cyc(1, 3'd5, 0, 0, WM, "pop_c1");
      cyc(0, 3'd0, 0, 0, WM, "pop_c2");
      cyc(0, 3'd0, 0, 0, WM, "pop_c3");
      cyc(0, 3'd0, 1, 0, ev(2'b00, 2'b01, 1, 1, 0, 0), "pop_c4");
      cyc(0, 3'd0, 0, 0, W2, "pop_c5");
      cyc(0, 3'd0, 0, 0, IDL, "pop_c6");

      // LOAD timeout
      cyc(1, 3'd1, 0, 0, WM, "to_c1");
      for (int i = 2; i <= 4; i++)
         cyc(0, 3'd0, 0, 0, WM, $sformatf("to_c%0d", i));
      cyc(0, 3'd0, 0, 0, ev(2'b00, 2'b00, 0, 1, 1, 1), "to_fin");
      cyc(0, 3'd0, 0, 0, IDL, "to_idle");

      // mem_ready on the last counter value beats timeout
      cyc(1, 3'd1, 0, 0, WM, "beat_c1");
      for (int i = 2; i <= 4; i++)
         cyc(0, 3'd0, 0, 0, WM, $sformatf("beat_c%0d", i));
      cyc(0, 3'd0, 1, 0, LD1, "beat_w1");
      cyc(0, 3'd0, 0, 0, IDL, "beat_idle");

      // Back to back 3,4,0,7 with start held during busy cycles
      cyc(1, 3'd3, 0, 0, ev(2'b10, 2'b10, 1, 1, 1, 0), "link");
      cyc(1, 3'd2, 0, 0, IDL, "link_idle");
      cyc(1, 3'd4, 0, 0, W2, "push");
      cyc(1, 3'd2, 0, 0, IDL, "push_idle");
      cyc(1, 3'd0, 0, 0, ev(2'b00, 2'b00, 0, 1, 1, 0), "none");
      cyc(1, 3'd2, 0, 0, IDL, "none_idle");
      cyc(1, 3'd7, 0, 0, ev(2'b00, 2'b00, 0, 1, 1, 1), "bad");
      cyc(0, 3'd0, 0, 0, IDL, "bad_idle");
      cyc(1, 3'd6, 0, 0, ev(2'b00, 2'b00, 1, 1, 1, 0), "alu_rt");
      cyc(0, 3'd0, 0, 0, IDL, "alu_rt_idle");

      // flush beats mem_ready in WAIT_MEM
      cyc(1, 3'd5, 0, 0, WM, "fl_wm");
      cyc(0, 3'd0, 1, 1, IDL, "fl_wm_idle");
      cyc(0, 3'd0, 1, 0, IDL, "fl_wm_quiet");

      // flush in WRITE1 of POP suppresses WRITE2
      cyc(1, 3'd5, 0, 0, WM, "fl_w1_wm");
      cyc(0, 3'd0, 1, 0, ev(2'b00, 2'b01, 1, 1, 0, 0), "fl_w1");
      cyc(0, 3'd0, 0, 1, IDL, "fl_w1_idle");

      // start together with flush in IDLE is dropped
      cyc(1, 3'd2, 0, 1, IDL, "fl_start");
      cyc(0, 3'd0, 0, 0, IDL, "fl_start_idle");

      // start while a load waits is ignored
      cyc(1, 3'd1, 0, 0, WM, "ign_c1");
      cyc(1, 3'd2, 0, 0, WM, "ign_c2");
      cyc(1, 3'd2, 1, 0, LD1, "ign_w1");
      cyc(0, 3'd0, 0, 0, IDL, "ign_idle");

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
